// File: rtl/ham_rx_stream.sv
// Serial Hamming(7,4) receiver: deserialise, correct single-bit errors,
// and deliver data words through a 2-entry FIFO with error statistics.
module ham_rx_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             ser_sof,
  output logic [3:0]       dout,
  output logic [2:0]       dout_syn,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [CNT_W-1:0] err_cnt,
  output logic             overflow,
  input  logic             clr_stats
);

  logic [2:0] bit_idx;
  logic [5:0] sr;
  logic [6:0] cw;
  logic [6:0] flip;
  logic [6:0] fix;
  logic [2:0] syn;
  logic [3:0] data;
  logic       push;
  logic       pop;
  logic       full;
  logic       err_max;
  logic [6:0] e0;
  logic [6:0] e1;
  logic [1:0] cnt;

  // cw[k-1] holds code position k; c7 is the bit arriving now
  assign cw   = {ser_in, sr};
  assign push = ser_valid & ~ser_sof & (bit_idx == 3'd6);
  assign pop  = dout_valid & dout_ready;
  assign full = (cnt == 2'd2);

  always_comb begin
    syn  = '0;
    flip = '0;
    syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
    syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
    syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
    if (syn != 3'd0)
      flip = 7'd1 << (syn - 3'd1);
  end

  assign fix  = cw ^ flip;
  assign data = {fix[2], fix[4], fix[5], fix[6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_idx <= '0;
      sr      <= '0;
    end else if (ser_valid) begin
      if (ser_sof) begin
        sr[0]   <= ser_in;
        bit_idx <= 3'd1;
      end else if (bit_idx == 3'd6) begin
        bit_idx <= '0;
      end else begin
        sr[bit_idx] <= ser_in;
        bit_idx     <= bit_idx + 3'd1;
      end
    end
  end

  // e0 is the head and keeps its value once popped empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= '0;
    end else begin
      unique case (1'b1)
        push & pop: begin
          if (full) begin
            e0 <= e1;
            e1 <= {data, syn};
          end else begin
            e0 <= {data, syn};
          end
        end
        pop: begin
          if (full) e0 <= e1;
          cnt <= cnt - 2'd1;
        end
        push: begin
          if (cnt == 2'd0) begin
            e0  <= {data, syn};
            cnt <= 2'd1;
          end else if (cnt == 2'd1) begin
            e1  <= {data, syn};
            cnt <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout       = e0[6:3];
  assign dout_syn   = e0[2:0];
  assign dout_valid = (cnt != 2'd0);
  assign err_max    = &err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else if (clr_stats) begin
      err_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push && syn != 3'd0 && !err_max)
        err_cnt <= err_cnt + 1'b1;
      if (push && full && !pop)
        overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ham_rx_stream.sv
// Bench for ham_rx_stream: directed scenarios plus randomized frames
// against a codeword-level reference model.
module tb_ham_rx_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_in = 1'b0;
  logic        ser_valid = 1'b0;
  logic        ser_sof = 1'b0;
  logic        dout_ready = 1'b1;
  logic        clr_stats = 1'b0;
  logic [3:0]  dout;
  logic [2:0]  dout_syn;
  logic        dout_valid;
  logic [15:0] err_cnt;
  logic        overflow;
  logic [3:0]  dout2;
  logic [2:0]  dout_syn2;
  logic        dout_valid2;
  logic [1:0]  err_cnt2;
  logic        overflow2;

  int n_chk = 0;
  int n_fail = 0;
  int exp_err = 0;

  ham_rx_stream #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in),
    .ser_valid(ser_valid), .ser_sof(ser_sof),
    .dout(dout), .dout_syn(dout_syn),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_cnt(err_cnt), .overflow(overflow),
    .clr_stats(clr_stats)
  );

  ham_rx_stream #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ser_in(ser_in),
    .ser_valid(ser_valid), .ser_sof(ser_sof),
    .dout(dout2), .dout_syn(dout_syn2),
    .dout_valid(dout_valid2), .dout_ready(dout_ready),
    .err_cnt(err_cnt2), .overflow(overflow2),
    .clr_stats(clr_stats)
  );

  always #5 clk = ~clk;

  function automatic logic [1:7] encode(input logic [3:0] d);
    logic [1:7] c;
    c[3] = d[3];
    c[5] = d[2];
    c[6] = d[1];
    c[7] = d[0];
    c[1] = c[3] ^ c[5] ^ c[7];
    c[2] = c[3] ^ c[6] ^ c[7];
    c[4] = c[5] ^ c[6] ^ c[7];
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic sof, input int gap);
    for (int g = 0; g < gap; g++) begin
      ser_valid = 1'b0;
      ser_sof   = 1'($urandom);
      ser_in    = 1'($urandom);
      step();
    end
    ser_valid = 1'b1;
    ser_sof   = sof;
    ser_in    = b;
    step();
    ser_valid = 1'b0;
    ser_sof   = 1'b0;
  endtask

  task automatic send_word(input logic [1:7] c, input int maxgap);
    for (int k = 1; k <= 7; k++)
      send_bit(c[k], k == 1, (k == 1) ? 0 : int'($urandom_range(maxgap, 0)));
  endtask

  task automatic do_clear();
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    exp_err = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    n_chk++;
    if ({dout_valid, dout, dout_syn, err_cnt, overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset: got v=%b d=%h s=%h e=%0d o=%b want all 0",
               dout_valid, dout, dout_syn, err_cnt, overflow);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_clean();
    logic [1:7] c = 7'b0011001;
    dout_ready = 1'b1;
    send_word(c, 0);
    n_chk++;
    if ({dout_valid, dout, dout_syn} !== {1'b1, 4'b1001, 3'b000}
        || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clean: got v=%b d=%b s=%b e=%0d want 1 1001 000 0",
               dout_valid, dout, dout_syn, err_cnt);
    end
    step();
  endtask

  task automatic test_single_flip();
    logic [1:7] c = 7'b0011101;
    send_word(c, 0);
    n_chk++;
    if ({dout_valid, dout, dout_syn} !== {1'b1, 4'b1001, 3'b101}
        || err_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL flip5: got v=%b d=%b s=%b e=%0d want 1 1001 101 1",
               dout_valid, dout, dout_syn, err_cnt);
    end
    step();
  endtask

  task automatic test_all_positions();
    logic [1:7] c0 = 7'b1100110;
    logic [1:7] c;
    do_clear();
    for (int k = 1; k <= 7; k++) begin
      c = c0;
      c[k] = ~c[k];
      send_word(c, 1);
      n_chk++;
      if ({dout_valid, dout, dout_syn} !== {1'b1, 4'b0110, 3'(k)}) begin
        n_fail++;
        $display("FAIL pos%0d: got v=%b d=%b s=%b want 1 0110 %b",
                 k, dout_valid, dout, dout_syn, 3'(k));
      end
      step();
    end
    n_chk++;
    if (err_cnt !== 16'd7) begin
      n_fail++;
      $display("FAIL pos_errcnt: got %0d want 7", err_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [1:7] f1 = encode(4'ha);
    logic [1:7] f2 = encode(4'h3);
    logic [1:7] f3 = encode(4'hc);
    f2[2] = ~f2[2];
    f3[6] = ~f3[6];
    do_clear();
    dout_ready = 1'b0;
    send_word(f1, 0);
    send_word(f2, 0);
    send_word(f3, 0);
    n_chk++;
    if ({dout_valid, dout, dout_syn, overflow} !== {1'b1, 4'ha, 3'd0, 1'b1}
        || err_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL ovf_full: got v=%b d=%h s=%0d o=%b e=%0d want 1 a 0 1 2",
               dout_valid, dout, dout_syn, overflow, err_cnt);
    end
    dout_ready = 1'b1;
    step();
    n_chk++;
    if ({dout_valid, dout, dout_syn} !== {1'b1, 4'h3, 3'd2}) begin
      n_fail++;
      $display("FAIL ovf_second: got v=%b d=%h s=%0d want 1 3 2",
               dout_valid, dout, dout_syn);
    end
    step();
    n_chk++;
    if ({dout_valid, dout, dout_syn} !== {1'b0, 4'h3, 3'd2}) begin
      n_fail++;
      $display("FAIL ovf_drain: got v=%b d=%h s=%0d want 0 3 2 (held)",
               dout_valid, dout, dout_syn);
    end
    do_clear();
    n_chk++;
    if (overflow !== 1'b0 || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL ovf_clear: got o=%b e=%0d want 0 0", overflow, err_cnt);
    end
  endtask

  task automatic test_clear_wins();
    logic [1:7] c = encode(4'h5);
    c[4] = ~c[4];
    do_clear();
    for (int k = 1; k <= 6; k++)
      send_bit(c[k], k == 1, 0);
    clr_stats = 1'b1;
    send_bit(c[7], 1'b0, 0);
    clr_stats = 1'b0;
    n_chk++;
    if ({dout_valid, dout, dout_syn} !== {1'b1, 4'h5, 3'd4}
        || err_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL clr_wins: got v=%b d=%h s=%0d e=%0d want 1 5 4 0",
               dout_valid, dout, dout_syn, err_cnt);
    end
    step();
  endtask

  task automatic test_resync();
    logic [1:7] junk = encode(4'hf);
    logic [1:7] c = encode(4'h9);
    int seen = 0;
    junk[1] = ~junk[1];
    for (int k = 1; k <= 4; k++) begin
      send_bit(junk[k], k == 1, 1);
      if (dout_valid) seen++;
    end
    for (int k = 1; k <= 7; k++) begin
      send_bit(c[k], k == 1, int'($urandom_range(3, 0)));
      if (dout_valid && k < 7) seen++;
    end
    n_chk++;
    if ({dout_valid, dout, dout_syn} !== {1'b1, 4'h9, 3'd0} || seen != 0) begin
      n_fail++;
      $display("FAIL resync: got v=%b d=%h s=%0d early=%0d want 1 9 0 0",
               dout_valid, dout, dout_syn, seen);
    end
    step();
    n_chk++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_once: got valid=%b want 0", dout_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [1:7] c = encode(4'h6);
    c[3] = ~c[3];
    dout_ready = 1'b0;
    send_word(c, 0);
    for (int k = 1; k <= 3; k++)
      send_bit(c[k], k == 1, 0);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({dout_valid, dout, dout_syn, err_cnt, overflow} !== '0) begin
      n_fail++;
      $display("FAIL async_rst: got v=%b d=%h s=%0d e=%0d o=%b want all 0",
               dout_valid, dout, dout_syn, err_cnt, overflow);
    end
    step();
    rst_n = 1'b1;
    dout_ready = 1'b1;
    exp_err = 0;
    c = encode(4'hb);
    for (int k = 2; k <= 7; k++) begin
      ser_valid = 1'b1;
      ser_sof = 1'b0;
      ser_in = c[k];
      step();
    end
    ser_valid = 1'b0;
    n_chk++;
    if (dout_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_partial: got valid=%b want 0", dout_valid);
    end
    c = encode(4'hd);
    c[7] = ~c[7];
    send_word(c, 0);
    n_chk++;
    if ({dout_valid, dout, dout_syn} !== {1'b1, 4'hd, 3'd7}) begin
      n_fail++;
      $display("FAIL post_rst: got v=%b d=%h s=%0d want 1 d 7",
               dout_valid, dout, dout_syn);
    end
    step();
  endtask

  task automatic test_saturate();
    logic [1:7] c;
    do_clear();
    for (int n = 0; n < 5; n++) begin
      c = encode(4'(n + 3));
      c[n + 1] = ~c[n + 1];
      send_word(c, 0);
      exp_err++;
      step();
    end
    n_chk++;
    if (err_cnt2 !== 2'd3 || err_cnt !== 16'(exp_err)) begin
      n_fail++;
      $display("FAIL saturate: got w2=%0d w16=%0d want 3 %0d",
               err_cnt2, err_cnt, exp_err);
    end
  endtask

  task automatic test_random();
    logic [1:7] c;
    logic [3:0] d;
    int pos;
    do_clear();
    dout_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      d = 4'($urandom);
      pos = int'($urandom_range(7, 0));
      c = encode(d);
      if (pos != 0) begin
        c[pos] = ~c[pos];
        exp_err++;
      end
      send_word(c, 2);
      n_chk++;
      if ({dout_valid, dout, dout_syn} !== {1'b1, d, 3'(pos)}) begin
        n_fail++;
        $display("FAIL rand%0d: got v=%b d=%h s=%0d want 1 %h %0d",
                 n, dout_valid, dout, dout_syn, d, pos);
      end
      step();
    end
    n_chk++;
    if (err_cnt !== 16'(exp_err)
        || err_cnt2 !== 2'((exp_err > 3) ? 3 : exp_err)) begin
      n_fail++;
      $display("FAIL rand_errcnt: got %0d/%0d want %0d (w2 sat 3)",
               err_cnt, err_cnt2, exp_err);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_clean();
    test_single_flip();
    test_all_positions();
    test_overflow();
    test_clear_wins();
    test_resync();
    test_async_reset();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
